// File: rtl/rx_i2s.sv
// rx_i2s: I2S capture. Bits are sampled on bclk rising edges, seen through clk_i; each left/right word leaves as bytes, MSB byte first.
// Latency: the first byte strobe comes one clk_i cycle after the word's last bit is sampled (plus SYNC_STAGES+1 cycles of input sync).
// Backpressure: bytes stall while wr_FIFO_full_i is high; a word that completes before the previous one has drained is dropped and overrun_o is set.
module rx_i2s #(
  parameter int TIMEOUT_CLKS = 1024,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] bit_depth_i,
  input  logic       bclk_i,
  input  logic       lrck_i,
  input  logic       sdata_i,
  output logic       wr_FIFO_en_o,
  output logic [7:0] wr_FIFO_data_o,
  input  logic       wr_FIFO_full_i,
  output logic       input_streaming_o,
  output logic       overrun_o
);

  // Bit-depth encodings shared with the transmitter; DoP carries 24-bit payloads.
  localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
  localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
  localparam logic [1:0] BIT_DEPTH_32  = 2'd2;
  localparam logic [1:0] BIT_DEPTH_DOP = 2'd3;

  // A single-flop chain is never safe, so fewer than two stages is clamped.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // The idle counter counts up to TIMEOUT_CLKS and then holds there.
  localparam int                IDLE_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT_CLKS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A completed word waiting to drain, kept left-justified so the next byte is always in [31:24].
  typedef struct packed {
    logic        pending;
    logic [2:0]  byte_left;
    logic [31:0] word;
  } hold_t;

  function automatic logic [5:0] depth_of(input logic [1:0] code);
    logic [5:0] d;
    d = 6'd24;
    case (code)
      BIT_DEPTH_16:  d = 6'd16;
      BIT_DEPTH_24:  d = 6'd24;
      BIT_DEPTH_32:  d = 6'd32;
      BIT_DEPTH_DOP: d = 6'd24;
      default:       d = 6'd24;
    endcase
    return d;
  endfunction

  // ------------------------------------------------------------------
  // Input synchronisation and bclk edge detection
  // ------------------------------------------------------------------
  logic [SYNC_N-1:0] bclk_sync;
  logic [SYNC_N-1:0] lrck_sync;
  logic [SYNC_N-1:0] sdata_sync;
  logic              bclk_prev;
  logic              bclk_s;
  logic              lrck_s;
  logic              sdata_s;
  logic              rise;

  // Matched chains keep lrck and sdata aligned with the bclk edge that samples them.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_N-2:0], bclk_i};
      lrck_sync  <= {lrck_sync[SYNC_N-2:0], lrck_i};
      sdata_sync <= {sdata_sync[SYNC_N-2:0], sdata_i};
      bclk_prev  <= bclk_sync[SYNC_N-1];
    end
  end

  assign bclk_s  = bclk_sync[SYNC_N-1];
  assign lrck_s  = lrck_sync[SYNC_N-1];
  assign sdata_s = sdata_sync[SYNC_N-1];
  assign rise    = bclk_s & ~bclk_prev;

  // ------------------------------------------------------------------
  // Loss-of-clock detection
  // ------------------------------------------------------------------
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;

  // Count clk_i cycles since the last bclk rise, saturating so the timeout fires only once.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      idle_cnt <= '0;
    end else if (rise) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_SAT) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = ~rise & (idle_cnt == IDLE_LAST);

  // ------------------------------------------------------------------
  // Framing FSM
  // ------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic       lrck_last;
  logic       channel_q;
  logic [5:0] depth_q;
  logic [5:0] bit_cnt;
  logic       start_lock;
  logic       slot_edge;
  logic       shift_en;
  logic       word_done;
  logic       abort;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock on the start of a left slot; fall back to idle when bclk goes away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_lock) state_d = ST_RUN;
      ST_RUN:  if (abort)      state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode per-cycle framing actions from the state and the current bclk rise.
  always_comb begin
    start_lock = 1'b0;
    slot_edge  = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_lock = rise & lrck_last & ~lrck_s;
      end
      ST_RUN: begin
        abort     = timeout;
        slot_edge = rise & (lrck_s != lrck_last);
        shift_en  = rise & (lrck_s == lrck_last) & (bit_cnt < depth_q);
        word_done = shift_en & (bit_cnt == (depth_q - 6'd1));
      end
      default: ;
    endcase
  end

  // Track word select on every rise, and latch depth and channel at slot boundaries.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      lrck_last <= 1'b0;
      channel_q <= 1'b0;
      depth_q   <= 6'd16;
    end else begin
      if (rise) begin
        lrck_last <= lrck_s;
      end
      if (start_lock) begin
        channel_q <= 1'b0;
        depth_q   <= depth_of(bit_depth_i);
      end else if (slot_edge) begin
        channel_q <= lrck_s;
      end
    end
  end

  // ------------------------------------------------------------------
  // Deserializer
  // ------------------------------------------------------------------
  logic [31:0] shift_q;
  logic [31:0] shift_next;
  logic [31:0] word_new;

  // The bit on the lrck-change rise belongs to the previous word, so each slot restarts the count there.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (abort || start_lock) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (slot_edge) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 6'd1;
      shift_q <= shift_next;
    end
  end

  assign shift_next = {shift_q[30:0], sdata_s};

  // Left-justify the finished word so its MSB byte lands in [31:24]; stale upper bits fall off.
  always_comb begin
    word_new = shift_next;
    case (depth_q)
      6'd16:   word_new = {shift_next[15:0], 16'h0000};
      6'd24:   word_new = {shift_next[23:0], 8'h00};
      default: word_new = shift_next;
    endcase
  end

  // ------------------------------------------------------------------
  // Byte drain
  // ------------------------------------------------------------------
  hold_t hold_q;
  logic  drain_fire;
  logic  last_byte;
  logic  accept;
  logic  drop;

  assign drain_fire = hold_q.pending & ~wr_FIFO_full_i;
  assign last_byte  = drain_fire & (hold_q.byte_left == 3'd1);
  // A word that completes on the final drain byte sees the hold as already free.
  assign accept     = word_done & (~hold_q.pending | last_byte);
  assign drop       = word_done & ~accept;

  // Load a completed word, or send one byte per cycle from the top of the hold register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q.word      <= word_new;
      hold_q.byte_left <= depth_q[5:3];
      hold_q.pending   <= 1'b1;
    end else if (drain_fire) begin
      hold_q.word      <= {hold_q.word[23:0], 8'h00};
      hold_q.byte_left <= hold_q.byte_left - 3'd1;
      if (last_byte) begin
        hold_q.pending <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Status
  // ------------------------------------------------------------------
  logic streaming_q;
  logic overrun_q;

  // Streaming is declared on the first finished left word and withdrawn on loss of bclk; overrun is sticky.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      streaming_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (abort) begin
        streaming_q <= 1'b0;
      end else if (word_done && !channel_q) begin
        streaming_q <= 1'b1;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign wr_FIFO_en_o      = drain_fire;
  assign wr_FIFO_data_o    = hold_q.word[31:24];
  assign input_streaming_o = streaming_q;
  assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_rx_i2s.sv
module tb_rx_i2s;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] bit_depth;
  logic       bclk;
  logic       lrck;
  logic       sdata;
  logic       en;
  logic [7:0] data;
  logic       full = 1'b0;
  logic       streaming;
  logic       overrun;

  always #5 clk = ~clk;

  rx_i2s dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .bit_depth_i      (bit_depth),
    .bclk_i           (bclk),
    .lrck_i           (lrck),
    .sdata_i          (sdata),
    .wr_FIFO_en_o     (en),
    .wr_FIFO_data_o   (data),
    .wr_FIFO_full_i   (full),
    .input_streaming_o(streaming),
    .overrun_o        (overrun)
  );

  int         chk_total = 0;
  int         chk_pass  = 0;
  int         cyc       = 0;
  logic [7:0] exp_q[$];
  logic [7:0] log_byte[64];
  int         log_cyc[64];
  int         log_n = 0;
  logic       full_force = 1'b0;
  logic       rand_full  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_total++;
    if (act === expv) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  always @(posedge clk) cyc++;

  // Sink full: forced by a test, or random back-pressure during the random rounds.
  always @(posedge clk) begin
    #1;
    full = full_force | (rand_full && ($urandom_range(0, 3) == 0));
  end

  // Scoreboard: every strobe must carry the next expected byte, and never while full.
  always @(negedge clk) begin
    if (reset_n) begin
      if (full) check("no_write_while_full", 32'(en), 0);
      if (en) begin
        if (log_n < 64) begin
          log_byte[log_n] = data;
          log_cyc[log_n]  = cyc;
        end
        log_n++;
        if (exp_q.size() == 0) begin
          chk_total++;
          $display("FAIL unexpected_byte: got %0h expected no strobe", data);
        end else begin
          check("byte_stream", 32'(data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One bclk period of 8 clk cycles; data changes with the falling edge.
  task automatic bit_out(input logic lr, input logic d);
    lrck  = lr;
    sdata = d;
    bclk  = 1'b0;
    tick(4);
    bclk  = 1'b1;
    tick(4);
  endtask

  // Reference: a d-bit word leaves as d/8 bytes, most significant first.
  task automatic push_word(input logic [31:0] w, input int d);
    for (int i = d / 8 - 1; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
  endtask

  // I2S slot: bit 0 is the one-bit delay slot, bits 1..d carry the word MSB first, then fill.
  task automatic send_slot(input logic lr, input logic [31:0] w, input int d, input int len,
                           input logic fill, input bit expect_word);
    if (expect_word) push_word(w, d);
    bit_out(lr, 1'($urandom_range(0, 1)));
    for (int k = 1; k < len; k++) bit_out(lr, (k <= d) ? w[d-k] : fill);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    log_n = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    check("drain_complete", 32'(exp_q.size()), 0);
    tick(6);
  endtask

  function automatic int depth_from_code(input logic [1:0] c);
    return (c == 2'd0) ? 16 : (c == 2'd2) ? 32 : 24;
  endfunction

  initial begin
    int         d;
    int         nf;
    int         t0;
    logic [1:0] dc;
    logic [31:0] mask;
    logic [31:0] w;

    reset_n   = 1'b0;
    bclk      = 1'b0;
    lrck      = 1'b1;
    sdata     = 1'b0;
    bit_depth = 2'd0;
    tick(3);
    check("reset_en", 32'(en), 0);
    check("reset_data", 32'(data), 0);
    check("reset_streaming", 32'(streaming), 0);
    check("reset_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    tick(2);

    // 16-bit, starting in the middle of a right slot.
    log_n = 0;
    for (int k = 0; k < 10; k++) bit_out(1'b1, 1'($urandom_range(0, 1)));
    check("no_bytes_before_lock", 32'(log_n), 0);
    check("not_streaming_before_lock", 32'(streaming), 0);
    send_slot(1'b0, 32'hA5C3, 16, 32, 1'b0, 1'b1);
    check("streaming_after_left", 32'(streaming), 1);
    send_slot(1'b1, 32'h1234, 16, 32, 1'b0, 1'b1);
    wait_drain();
    check("t16_count", 32'(log_n), 4);
    check("t16_b0", 32'(log_byte[0]), 32'hA5);
    check("t16_b1", 32'(log_byte[1]), 32'hC3);
    check("t16_b2", 32'(log_byte[2]), 32'h12);
    check("t16_b3", 32'(log_byte[3]), 32'h34);
    check("t16_overrun", 32'(overrun), 0);

    // 24-bit words in 32-bit slots with trailing ones.
    bit_depth = 2'd1;
    do_reset();
    send_slot(1'b1, 32'h0, 24, 32, 1'b1, 1'b0);
    send_slot(1'b0, 32'h123456, 24, 32, 1'b1, 1'b1);
    send_slot(1'b1, 32'hABCDEF, 24, 32, 1'b1, 1'b1);
    wait_drain();
    check("t24_count", 32'(log_n), 6);
    check("t24_b0", 32'(log_byte[0]), 32'h12);
    check("t24_b1", 32'(log_byte[1]), 32'h34);
    check("t24_b2", 32'(log_byte[2]), 32'h56);
    check("t24_b3", 32'(log_byte[3]), 32'hAB);
    check("t24_b4", 32'(log_byte[4]), 32'hCD);
    check("t24_b5", 32'(log_byte[5]), 32'hEF);

    // 32-bit word held back by a full sink.
    bit_depth = 2'd2;
    do_reset();
    full_force = 1'b1;
    send_slot(1'b1, 32'h0, 32, 33, 1'b0, 1'b0);
    send_slot(1'b0, 32'hDEADBEEF, 32, 33, 1'b0, 1'b1);
    tick(20);
    check("t32_no_bytes_while_full", 32'(log_n), 0);
    full_force = 1'b0;
    wait_drain();
    check("t32_count", 32'(log_n), 4);
    check("t32_b0", 32'(log_byte[0]), 32'hDE);
    check("t32_b1", 32'(log_byte[1]), 32'hAD);
    check("t32_b2", 32'(log_byte[2]), 32'hBE);
    check("t32_b3", 32'(log_byte[3]), 32'hEF);
    check("t32_back_to_back", 32'(log_cyc[3] - log_cyc[0]), 3);
    check("t32_overrun", 32'(overrun), 0);

    // bclk stops mid-word: timeout, partial word dropped, relock afterwards.
    bit_depth = 2'd0;
    do_reset();
    send_slot(1'b1, 32'h0, 16, 20, 1'b0, 1'b0);
    send_slot(1'b0, 32'h0F1E, 16, 17, 1'b0, 1'b1);
    send_slot(1'b1, 32'h2D3C, 16, 17, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) bit_out(1'b0, 1'($urandom_range(0, 1)));
    t0 = log_n;
    tick(900);
    check("streaming_before_timeout", 32'(streaming), 1);
    tick(200);
    check("streaming_after_timeout", 32'(streaming), 0);
    check("partial_word_dropped", 32'(log_n - t0), 0);
    send_slot(1'b1, 32'h0, 16, 17, 1'b0, 1'b0);
    send_slot(1'b0, 32'h4B5A, 16, 17, 1'b0, 1'b1);
    check("streaming_relock", 32'(streaming), 1);
    send_slot(1'b1, 32'h6978, 16, 17, 1'b0, 1'b1);
    wait_drain();

    // Two words while full: the second is dropped and overrun sticks until reset.
    do_reset();
    full_force = 1'b1;
    send_slot(1'b1, 32'h0, 16, 17, 1'b0, 1'b0);
    send_slot(1'b0, 32'hC0DE, 16, 17, 1'b0, 1'b1);
    send_slot(1'b1, 32'hBAD0, 16, 17, 1'b0, 1'b0);
    check("overrun_set", 32'(overrun), 1);
    full_force = 1'b0;
    wait_drain();
    check("overrun_sticky", 32'(overrun), 1);
    check("overrun_first_word_only", 32'(log_n), 2);
    check("streaming_before_reset", 32'(streaming), 1);
    reset_n = 1'b0;
    tick(1);
    check("rst_en", 32'(en), 0);
    check("rst_data", 32'(data), 0);
    check("rst_streaming", 32'(streaming), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    tick(2);

    // Random depths, words, slot lengths and sink back-pressure.
    for (int r = 0; r < 6; r++) begin
      dc        = 2'($urandom_range(0, 3));
      bit_depth = dc;
      d         = depth_from_code(dc);
      mask      = (d == 32) ? 32'hFFFF_FFFF : ((32'h1 << d) - 32'h1);
      do_reset();
      rand_full = 1'b1;
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) bit_out(1'b1, 1'($urandom_range(0, 1)));
      nf = int'($urandom_range(2, 4));
      for (int f = 0; f < nf; f++) begin
        w = $urandom() & mask;
        send_slot(1'b0, w, d, d + 1 + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
        w = $urandom() & mask;
        send_slot(1'b1, w, d, d + 1 + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      end
      wait_drain();
      rand_full = 1'b0;
      check("rand_overrun", 32'(overrun), 0);
      check("rand_streaming", 32'(streaming), 1);
      check("rand_byte_count", 32'(log_n), 32'(nf * 2 * (d / 8)));
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
